// File: rtl/operand_extend_pipe_if.sv
// operand_extend_pipe_if: valid/ready handshake bundle for the operand extender
//   in_valid/in_ready/in_data/in_fw/in_sext : request side (field, width, sign mode)
//   out_valid/out_ready/out_data/out_err    : result side (extended value, illegal-width flag)
//   master : producer/consumer side (testbench or decode stage)
//   slave  : the extender itself
interface operand_extend_pipe_if #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16
);
   localparam int FW_W = $clog2(IN_W + 1);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [FW_W-1:0]  in_fw;
   logic             in_sext;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_err;
   modport master (
      output in_valid, in_data, in_fw, in_sext, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );
   modport slave (
      input  in_valid, in_data, in_fw, in_sext, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/operand_extend_pipe.sv
// operand_extend_pipe: per-transaction-width sign/zero extender with 2-entry output FIFO
//   clk      : rising-edge clock
//   rst_b    : asynchronous active-low reset
//   bus      : slave side of the request/result handshake bundle
//   conv_cnt : wrap-around count of accepted conversions
module operand_extend_pipe #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_b,
   operand_extend_pipe_if.slave bus,
   output logic [CNT_W-1:0]     conv_cnt
);
   localparam int FW_W = $clog2(IN_W + 1);
   logic [1:0]       count_q, count_d;
   logic [OUT_W:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] conv_q, conv_d;
   logic             push, pop, illegal, sign;
   logic [FW_W-1:0]  fw, msb;
   logic [OUT_W-1:0] dz, mask, ext;
   logic [OUT_W:0]   entry;
   assign illegal = (bus.in_fw == '0) || (int'(bus.in_fw) > IN_W);
   assign fw      = illegal ? FW_W'(IN_W) : bus.in_fw;
   assign msb     = fw - FW_W'(1);
   assign dz      = OUT_W'(bus.in_data);
   assign mask    = ~({OUT_W{1'b1}} << fw);
   assign sign    = bus.in_sext & dz[msb];
   assign ext     = (dz & mask) | (sign ? ~mask : '0);
   assign entry   = {illegal, ext};
   // in_ready depends only on registered count (and reset), never on out_ready
   assign bus.in_ready  = rst_b && (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_data  = head_q[OUT_W-1:0];
   assign bus.out_err   = head_q[OUT_W];
   assign conv_cnt      = conv_q;
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;
   // head/tail shift structure: new entry goes to head when head is free (or being popped)
   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      conv_d  = conv_q + CNT_W'(push);
      head_d  = (pop && count_q == 2'd2) ? tail_q :
                (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) ? entry : head_q;
      tail_d  = (push && count_q == 2'd1 && !pop) ? entry : tail_q;
   end
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         conv_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         conv_q  <= conv_d;
      end
   end
endmodule

// File: tb/tb_operand_extend_pipe.sv
// tb_operand_extend_pipe: directed self-checking bench for operand_extend_pipe
module tb_operand_extend_pipe;
   logic       clk = 1'b0;
   logic       rst_b;
   logic [7:0] conv_cnt;
   int         compared = 0;
   int         mismatched = 0;
   operand_extend_pipe_if #(.IN_W(9), .OUT_W(16)) bus ();
   operand_extend_pipe #(.IN_W(9), .OUT_W(16), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .bus      (bus),
      .conv_cnt (conv_cnt)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(negedge clk);
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [8:0] d, input logic [3:0] fw, input logic s);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_fw    = fw;
      bus.in_sext  = s;
   endtask
   task automatic single(input string tag, input logic [8:0] d, input logic [3:0] fw,
                         input logic s, input logic [15:0] exp_d, input logic exp_e);
      drive(1'b1, d, fw, s);
      bus.out_ready = 1'b0;
      step();
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
      check({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
   endtask
   initial begin
      rst_b = 1'b0;
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      bus.out_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      check("rst_conv", 32'(conv_cnt), 32'd0);
      rst_b = 1'b1;
      step();
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      single("t1", 9'h166, 4'd9, 1'b1, 16'hFF66, 1'b0);
      single("t2_sext", 9'h1F6, 4'd5, 1'b1, 16'hFFF6, 1'b0);
      single("t2_zext", 9'h1F6, 4'd5, 1'b0, 16'h0016, 1'b0);
      single("t3_pos", 9'h0FF, 4'd9, 1'b1, 16'h00FF, 1'b0);
      single("t3_neg", 9'h100, 4'd9, 1'b1, 16'hFF00, 1'b0);
      single("t3_fw0", 9'h1FF, 4'd0, 1'b1, 16'hFFFF, 1'b1);
      single("t3_fw1", 9'h001, 4'd1, 1'b1, 16'hFFFF, 1'b0);
      single("t3_fw10", 9'h0AA, 4'd10, 1'b0, 16'h00AA, 1'b1);
      check("conv_after_singles", 32'(conv_cnt), 32'd8);
      // backpressure: three pushes with out_ready low
      drive(1'b1, 9'h001, 4'd9, 1'b0);
      step();
      check("t4_ready_c1", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 9'h002, 4'd9, 1'b0);
      step();
      check("t4_ready_c2", 32'(bus.in_ready), 32'd0);
      check("t4_head_a", 32'(bus.out_data), 32'h0001);
      drive(1'b1, 9'h003, 4'd9, 1'b0);
      step();
      check("t4_held_ready", 32'(bus.in_ready), 32'd0);
      check("t4_held_data", 32'(bus.out_data), 32'h0001);
      check("t4_held_conv", 32'(conv_cnt), 32'd10);
      bus.out_ready = 1'b1;
      step();
      check("t4_head_b", 32'(bus.out_data), 32'h0002);
      check("t4_ready_back", 32'(bus.in_ready), 32'd1);
      check("t4_valid_b", 32'(bus.out_valid), 32'd1);
      step();
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      check("t4_head_c", 32'(bus.out_data), 32'h0003);
      check("t4_conv", 32'(conv_cnt), 32'd11);
      step();
      check("t4_empty", 32'(bus.out_valid), 32'd0);
      // streaming with one entry resident
      bus.out_ready = 1'b0;
      drive(1'b1, 9'h010, 4'd9, 1'b0);
      step();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 9'(9'h011 + i), 4'd9, 1'b0);
         step();
         check("t5_ready", 32'(bus.in_ready), 32'd1);
         check("t5_data", 32'(bus.out_data), 32'(16'h0011 + i));
      end
      check("t5_conv", 32'(conv_cnt), 32'd22);
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      step();
      check("t5_empty", 32'(bus.out_valid), 32'd0);
      // fill to conv_cnt=255 with two entries buffered, then reset
      drive(1'b1, 9'h055, 4'd9, 1'b0);
      for (int i = 0; i < 232; i++) step();
      bus.out_ready = 1'b0;
      step();
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      check("t6_conv255", 32'(conv_cnt), 32'd255);
      check("t6_full", 32'(bus.in_ready), 32'd0);
      check("t6_valid", 32'(bus.out_valid), 32'd1);
      rst_b = 1'b0;
      #1;
      check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_conv", 32'(conv_cnt), 32'd0);
      check("t6_rst_data", 32'(bus.out_data), 32'd0);
      check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
      step();
      rst_b = 1'b1;
      step();
      bus.out_ready = 1'b1;
      drive(1'b1, 9'h077, 4'd9, 1'b1);
      for (int i = 0; i < 255; i++) step();
      check("t6_wrap_255", 32'(conv_cnt), 32'd255);
      step();
      drive(1'b0, 9'h0, 4'd0, 1'b0);
      check("t6_wrap_0", 32'(conv_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
